// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - fixed-latency instruction fetch responder with preload port
// Optional build macro: FETCH_WRITE_FORWARD_EN (same-cycle load data forwarded into fetch).
module instr_fetch_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_address,
    input  logic        flush,
    input  logic        stall,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] instruction,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    output logic        addr_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]        mem [DEPTH_WORDS];

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [31:0]        pc_q    [LATENCY];
    logic [31:0]        pc_d    [LATENCY];
    logic [31:0]        instr_q [LATENCY];
    logic [31:0]        instr_d [LATENCY];
    logic [LATENCY-1:0] fault_q, fault_d;

    logic          fetch_fault;
    logic [AW-1:0] fetch_idx;
    logic          load_ok;
    logic [AW-1:0] load_idx;
    logic          mem_we;
    logic [31:0]   rd_data;

    // Any address bit above the store or in the byte offset makes the access illegal.
    always_comb begin
        fetch_fault = (ins_address[1:0] != 2'b00) || (ins_address[31:AW+2] != '0);
        fetch_idx   = ins_address[AW+1:2];
        load_ok     = (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);
        load_idx    = load_addr[AW+1:2];
        mem_we      = reset && load_en && load_ok;
    end

    always_comb begin
        rd_data = mem[fetch_idx];
`ifdef FETCH_WRITE_FORWARD_EN
        if (mem_we && !fetch_fault && (load_idx == fetch_idx)) begin
            rd_data = load_data;
        end
`endif
    end

    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d[0] = 1'b1;
            fault_d[0] = fetch_fault;
            pc_d[0]    = ins_address;
            instr_d[0] = fetch_fault ? 32'h0000_0000 : rd_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                fault_d[i] = fault_q[i-1];
                pc_d[i]    = pc_q[i-1];
                instr_d[i] = instr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            fault_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            for (int i = 0; i < LATENCY; i++) begin
                pc_q[i]    <= pc_d[i];
                instr_q[i] <= instr_d[i];
            end
        end
    end

    // Program image is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_idx] <= load_data;
        end
    end

    assign instruction = instr_q[LATENCY-1];
    assign ins_pc      = pc_q[LATENCY-1];
    assign ins_valid   = valid_q[LATENCY-1];
    assign addr_fault  = fault_q[LATENCY-1];
endmodule
